rf_arbiter: RTL and testbench
=============================

Name: rf_arbiter

Overview:
Owns the 8x8 register file's ports and shares them between NUM_REQ requesters, such as the core writeback stage and a debug/load unit.
After reset it walks every register and writes 0, because the register file itself has no reset.
It then grants one read or write transaction per cycle using round-robin priority, and returns registered read data one cycle after acceptance.
It sits directly in front of the register file; the register file's ports are driven only by this block.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
DATA_W, 8, register width
ADDR_W, 3, register index width; NUM_REGS = 2**ADDR_W

Ports:
CLK  input  1  clock, rising edge
RST_N  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  per-requester grant; at most one bit high
req_write  input  NUM_REQ  1 = write, 0 = read
req_ra  input  NUM_REQ*ADDR_W  read index A; requester i uses [i*ADDR_W +: ADDR_W]
req_rb  input  NUM_REQ*ADDR_W  read index B, and also the write destination
req_wdata  input  NUM_REQ*DATA_W  write data, same slicing as req_ra
rsp_valid  output  NUM_REQ  one-cycle pulse marking completion for requester i
rsp_a  output  DATA_W  registered value of register ra
rsp_b  output  DATA_W  registered value of register rb (pre-write value for writes)
rsp_cmp  output  1  registered (rsp_a == rsp_b)
init_done  output  1  high once the clear sweep has finished
rf_R1  output  ADDR_W  register file read index 1
rf_R2  output  ADDR_W  register file read index 2 / write index
rf_regWrite  output  1  register file write enable
rf_writeValue  output  DATA_W  register file write data
rf_val1  input  DATA_W  register file read data 1
rf_val2  input  DATA_W  register file read data 2
rf_cmp  input  1  register file equality flag

Behaviour:
- Reset (RST_N low, asynchronous):
  - State = INIT, init_cnt = 0, rr_ptr = 0.
  - rsp_valid = 0, rsp_a = 0, rsp_b = 0, rsp_cmp = 0, init_done = 0.
  - req_ready = 0 and rf_regWrite = 0 for as long as RST_N is low.
- States are INIT and RUN; there is no other state.
- INIT:
  - Drive rf_regWrite = 1, rf_R2 = init_cnt, rf_writeValue = 0, rf_R1 = 0; req_ready = 0.
  - init_cnt increments every cycle.
  - When init_cnt == NUM_REGS-1, the next state is RUN and init_done is set. The sweep therefore takes exactly NUM_REGS cycles.
- RUN grant selection:
  - Candidates are requesters with req_valid = 1.
  - Search starts at rr_ptr and proceeds upward, wrapping modulo NUM_REQ. The first valid requester found is g.
  - req_ready[g] = 1 in the same cycle (combinational from req_valid and rr_ptr). A transfer happens when valid and ready are both high.
- RUN pointer update:
  - On a transfer, rr_ptr <= (g+1) mod NUM_REQ.
  - With no valid requester, rr_ptr holds.
- RUN register file drive for the accepted request: rf_R1 = ra[g], rf_R2 = rb[g], rf_writeValue = wdata[g], rf_regWrite = req_write[g].
- RUN idle drive: rf_R1 = rf_R2 = 0, rf_writeValue = 0, rf_regWrite = 0.
- Response, latency 1:
  - On the edge ending an accepted cycle: rsp_a <= rf_val1, rsp_b <= rf_val2, rsp_cmp <= rf_cmp, rsp_valid <= onehot(g).
  - rsp_valid is 0 in every cycle that follows a cycle with no transfer.
  - rsp_a, rsp_b and rsp_cmp hold their last values when no response is issued.
- Writes:
  - The write commits at the acceptance edge.
  - rsp_b returns the old content of rb; the response acts as a write acknowledge.
  - A read of the same register accepted in the next cycle returns the new value.
  - A write and a read can never occur in the same cycle, since only one grant is issued per cycle.
- Request hold rules:
  - A requester holds valid and its fields stable until ready.
  - Dropping valid before ready is allowed; the request is simply not performed.
- Reset asserted mid-sweep or mid-RUN:
  - Everything returns to reset values immediately.
  - A pending response is discarded.
  - The sweep restarts from register 0 after deassertion.
- init_done stays 1 until the next reset.

Decomposition:
- Package rf_arb_pkg holds:
  - DATA_W and ADDR_W defaults, and NUM_REGS;
  - typedef enum logic {INIT, RUN} rf_arb_state_t;
  - the function onehot(idx).
- Sub-module rr_arbiter (parameter N) is natural:
  - inputs req[N] and ptr; outputs gnt[N], gnt_idx and any.
  - It is purely combinational; rr_ptr lives in rf_arbiter.

Test Plan:
- Reset, then 8 cycles with no requests:
  - rf_regWrite = 1 with rf_R2 = 0,1,...,7 and writeValue = 0.
  - init_done rises after the 8th edge.
  - req_ready stays 0 during INIT even with req_valid = 2'b11.
- After init, requester 0 writes reg 5 = 8'hA7, then requester 0 reads ra = 5, rb = 5:
  - Write response gives rsp_b = 8'h00 and rsp_valid = 2'b01.
  - Read response gives rsp_a = rsp_b = 8'hA7, rsp_cmp = 1, one cycle after acceptance.
- Both requesters hold valid continuously with reads:
  - Grants alternate 0,1,0,1,... starting with requester 0.
  - rsp_valid follows one cycle later: 01,10,01,...
- Only requester 1 valid for 3 cycles, then both valid:
  - Requester 1 is granted 3 times.
  - The next grant goes to requester 0 (rr_ptr = 0 after wrap).
- Assert RST_N at sweep cycle 4 and again one cycle after a read is accepted:
  - rsp_valid = 0 immediately and init_done = 0.
  - The sweep restarts at rf_R2 = 0 and lasts a full 8 cycles.
- Requester 1 writes reg 2 = 8'h3C, then reads ra = 2, rb = 3:
  - rsp_a = 8'h3C, rsp_b = 0, rsp_cmp = 0.
  - With no requests after that, rf_regWrite = 0 on every idle cycle.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// Shared types and defaults for the register-file arbiter.
// Combinational helpers only; no latency and no flow control of its own.
package rf_arb_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;
  localparam int NUM_REGS   = 2 ** ADDR_W_DEF;
  localparam int MAX_REQ    = 4;

  typedef enum logic {INIT, RUN} rf_arb_state_t;

  function automatic logic [MAX_REQ-1:0] onehot(input logic [1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick starting at ptr, wrapping modulo N.
// Purely combinational: zero latency, grants only among asserted requests.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic          any
);

  int k;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    k       = 0;
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr) + i) % N;
      if (!any && req[k]) begin
        any     = 1'b1;
        gnt_idx = PW'(k);
        gnt[k]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_arbiter.sv
// Clears the register file after reset, then grants one access per cycle round-robin.
// Read data returns one cycle after acceptance; at most one req_ready bit high, none during the sweep.
module rf_arbiter
  import rf_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_ra,
  input  logic [NUM_REQ*ADDR_W-1:0] req_rb,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_a,
  output logic [DATA_W-1:0]         rsp_b,
  output logic                      rsp_cmp,
  output logic                      init_done,
  output logic [ADDR_W-1:0]         rf_R1,
  output logic [ADDR_W-1:0]         rf_R2,
  output logic                      rf_regWrite,
  output logic [DATA_W-1:0]         rf_writeValue,
  input  logic [DATA_W-1:0]         rf_val1,
  input  logic [DATA_W-1:0]         rf_val2,
  input  logic                      rf_cmp
);

  localparam int PW     = $clog2(NUM_REQ);
  localparam int N_REGS = 2 ** ADDR_W;

  rf_arb_state_t        state_q;
  logic [ADDR_W-1:0]    init_cnt_q;
  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]   rsp_valid_q;
  logic [DATA_W-1:0]    rsp_a_q, rsp_b_q;
  logic                 rsp_cmp_q, init_done_q;

  logic [NUM_REQ-1:0]   gnt;
  logic [PW-1:0]        gnt_idx;
  logic                 any;
  logic                 run;

  rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_rr (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  assign run       = (state_q == RUN);
  assign req_ready = run ? gnt : '0;
  assign rr_ptr_d  = (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + PW'(1);

  // Write enable is gated by RST_N directly so the file is never written while reset is held.
  always_comb begin
    rf_R1         = '0;
    rf_R2         = '0;
    rf_writeValue = '0;
    rf_regWrite   = 1'b0;
    if (!run) begin
      rf_R2       = init_cnt_q;
      rf_regWrite = RST_N;
    end else if (any) begin
      rf_R1         = req_ra[int'(gnt_idx)*ADDR_W +: ADDR_W];
      rf_R2         = req_rb[int'(gnt_idx)*ADDR_W +: ADDR_W];
      rf_writeValue = req_wdata[int'(gnt_idx)*DATA_W +: DATA_W];
      rf_regWrite   = req_write[gnt_idx];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      rr_ptr_q    <= '0;
      rsp_valid_q <= '0;
      rsp_a_q     <= '0;
      rsp_b_q     <= '0;
      rsp_cmp_q   <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      case (state_q)
        INIT: begin
          init_cnt_q <= init_cnt_q + 1'b1;
          if (init_cnt_q == ADDR_W'(N_REGS - 1)) begin
            state_q     <= RUN;
            init_done_q <= 1'b1;
          end
        end
        RUN: begin
          if (any) begin
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= NUM_REQ'(onehot(2'(gnt_idx)));
            rsp_a_q     <= rf_val1;
            rsp_b_q     <= rf_val2;
            rsp_cmp_q   <= rf_cmp;
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_a     = rsp_a_q;
  assign rsp_b     = rsp_b_q;
  assign rsp_cmp   = rsp_cmp_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_rf_arbiter.sv
// Directed bench for rf_arbiter with a behavioural 8x8 register file attached.
module tb_rf_arbiter;

  logic        CLK, RST_N;
  logic [1:0]  req_valid, req_ready, req_write, rsp_valid;
  logic [5:0]  req_ra, req_rb;
  logic [15:0] req_wdata;
  logic [7:0]  rsp_a, rsp_b, rf_writeValue, rf_val1, rf_val2;
  logic        rsp_cmp, init_done, rf_regWrite, rf_cmp;
  logic [2:0]  rf_R1, rf_R2;

  int n_chk  = 0;
  int n_fail = 0;

  // Register file has no reset; seed it with junk so the clear sweep is observable.
  logic [7:0] rf_mem [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

  assign rf_val1 = rf_mem[rf_R1];
  assign rf_val2 = rf_mem[rf_R2];
  assign rf_cmp  = (rf_val1 == rf_val2);
  always @(posedge CLK) if (rf_regWrite) rf_mem[rf_R2] <= rf_writeValue;

  rf_arbiter #(.NUM_REQ(2), .DATA_W(8), .ADDR_W(3)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_ra(req_ra), .req_rb(req_rb), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_a(rsp_a), .rsp_b(rsp_b), .rsp_cmp(rsp_cmp),
    .init_done(init_done),
    .rf_R1(rf_R1), .rf_R2(rf_R2), .rf_regWrite(rf_regWrite),
    .rf_writeValue(rf_writeValue),
    .rf_val1(rf_val1), .rf_val2(rf_val2), .rf_cmp(rf_cmp)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic [1:0]  vld;
    logic [1:0]  wr;
    logic [5:0]  ra;
    logic [5:0]  rb;
    logic [15:0] wd;
    logic [1:0]  ready;
    logic        we;
    logic [1:0]  rsp;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        cmp;
  } vec_t;

  vec_t vt [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Checks ncyc sweep cycles starting now; a full sweep must end with init_done high.
  task automatic sweep(input int ncyc);
    req_valid = 2'b11;
    #1;
    for (int k = 0; k < ncyc; k++) begin
      chk("sweep_we", 32'(rf_regWrite), 32'd1);
      chk("sweep_r2", 32'(rf_R2), 32'(k));
      chk("sweep_wv", 32'(rf_writeValue), 32'd0);
      chk("sweep_rdy", 32'(req_ready), 32'd0);
      chk("sweep_done", 32'(init_done), 32'd0);
      @(posedge CLK);
      #1;
    end
    if (ncyc == 8) chk("init_done_rise", 32'(init_done), 32'd1);
    req_valid = 2'b00;
  endtask

  task automatic chk_reset_vals();
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_a", 32'(rsp_a), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_we", 32'(rf_regWrite), 32'd0);
  endtask

  initial begin
    // ra/rb octal: high digit = requester 1, low digit = requester 0
    vt[0]  = '{2'b01, 2'b01, 6'o00, 6'o05, 16'h00A7, 2'b01, 1'b1, 2'b01, 8'h00, 8'h00, 1'b1};
    vt[1]  = '{2'b01, 2'b00, 6'o05, 6'o05, 16'h0000, 2'b01, 1'b0, 2'b01, 8'hA7, 8'hA7, 1'b1};
    vt[2]  = '{2'b00, 2'b00, 6'o55, 6'o05, 16'h0000, 2'b00, 1'b0, 2'b00, 8'hA7, 8'hA7, 1'b1};
    vt[3]  = '{2'b10, 2'b00, 6'o55, 6'o05, 16'h0000, 2'b10, 1'b0, 2'b10, 8'hA7, 8'h00, 1'b0};
    vt[4]  = '{2'b10, 2'b00, 6'o55, 6'o05, 16'h0000, 2'b10, 1'b0, 2'b10, 8'hA7, 8'h00, 1'b0};
    vt[5]  = '{2'b10, 2'b00, 6'o55, 6'o05, 16'h0000, 2'b10, 1'b0, 2'b10, 8'hA7, 8'h00, 1'b0};
    vt[6]  = '{2'b11, 2'b00, 6'o55, 6'o05, 16'h0000, 2'b01, 1'b0, 2'b01, 8'hA7, 8'hA7, 1'b1};
    vt[7]  = '{2'b11, 2'b00, 6'o55, 6'o05, 16'h0000, 2'b10, 1'b0, 2'b10, 8'hA7, 8'h00, 1'b0};
    vt[8]  = '{2'b11, 2'b00, 6'o55, 6'o05, 16'h0000, 2'b01, 1'b0, 2'b01, 8'hA7, 8'hA7, 1'b1};
    vt[9]  = '{2'b11, 2'b00, 6'o55, 6'o05, 16'h0000, 2'b10, 1'b0, 2'b10, 8'hA7, 8'h00, 1'b0};
    vt[10] = '{2'b10, 2'b10, 6'o05, 6'o25, 16'h3C00, 2'b10, 1'b1, 2'b10, 8'h00, 8'h00, 1'b1};
    vt[11] = '{2'b10, 2'b00, 6'o25, 6'o35, 16'h0000, 2'b10, 1'b0, 2'b10, 8'h3C, 8'h00, 1'b0};
    vt[12] = '{2'b00, 2'b00, 6'o00, 6'o00, 16'h0000, 2'b00, 1'b0, 2'b00, 8'h3C, 8'h00, 1'b0};
    vt[13] = '{2'b00, 2'b00, 6'o00, 6'o00, 16'h0000, 2'b00, 1'b0, 2'b00, 8'h3C, 8'h00, 1'b0};

    RST_N     = 1'b0;
    req_valid = 2'b11;
    req_write = 2'b00;
    req_ra    = '0;
    req_rb    = '0;
    req_wdata = '0;
    #12;
    chk_reset_vals();
    RST_N = 1'b1;
    sweep(8);

    for (int i = 0; i < 14; i++) begin
      req_valid = vt[i].vld;
      req_write = vt[i].wr;
      req_ra    = vt[i].ra;
      req_rb    = vt[i].rb;
      req_wdata = vt[i].wd;
      #1;
      chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'(vt[i].ready));
      chk($sformatf("v%0d_we", i), 32'(rf_regWrite), 32'(vt[i].we));
      @(posedge CLK);
      #1;
      chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'(vt[i].rsp));
      chk($sformatf("v%0d_rsp_a", i), 32'(rsp_a), 32'(vt[i].a));
      chk($sformatf("v%0d_rsp_b", i), 32'(rsp_b), 32'(vt[i].b));
      chk($sformatf("v%0d_rsp_cmp", i), 32'(rsp_cmp), 32'(vt[i].cmp));
    end

    // Reset one cycle after a read is accepted
    req_valid = 2'b01; req_write = 2'b00; req_ra = 6'o05; req_rb = 6'o05;
    #1;
    @(posedge CLK);
    #1;
    chk("pre_rst_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("pre_rst_rsp_a", 32'(rsp_a), 32'hA7);
    #2;
    RST_N = 1'b0;
    #1;
    chk_reset_vals();
    @(posedge CLK);
    #3;
    chk("rst_hold_we", 32'(rf_regWrite), 32'd0);
    chk("rst_hold_rsp", 32'(rsp_valid), 32'd0);
    RST_N = 1'b1;

    // Reset again at sweep cycle 4
    sweep(4);
    #2;
    RST_N = 1'b0;
    #1;
    chk_reset_vals();
    @(posedge CLK);
    #3;
    RST_N = 1'b1;
    sweep(8);

    // Sweep must have wiped the A7 and 3C written earlier
    req_valid = 2'b01; req_write = 2'b00; req_ra = 6'o05; req_rb = 6'o02;
    #1;
    chk("post_ready", 32'(req_ready), 32'd1);
    @(posedge CLK);
    #1;
    req_valid = 2'b00;
    chk("post_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("post_rsp_a", 32'(rsp_a), 32'd0);
    chk("post_rsp_b", 32'(rsp_b), 32'd0);
    chk("post_rsp_cmp", 32'(rsp_cmp), 32'd1);
    @(posedge CLK);
    #1;
    chk("post_idle_rsp", 32'(rsp_valid), 32'd0);
    chk("post_idle_we", 32'(rf_regWrite), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
